// File: rtl/paula_floppy_dma_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// paula_floppy_dma_ctrl_pkg
// Shared Paula floppy definitions: DSKLEN register bit positions and the
// floppy DMA controller state encoding.
// -----------------------------------------------------------------------------
package paula_floppy_dma_ctrl_pkg;

  // DSKLEN register layout
  localparam int unsigned DSKLEN_DMAEN   = 15;
  localparam int unsigned DSKLEN_WRITE   = 14;
  localparam int unsigned DSKLEN_LEN_MSB = 13;
  localparam int unsigned DSKLEN_LEN_W   = 14;

  // Floppy DMA controller states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_SYNC  = 3'd2,
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DRAIN = 3'd5,
    ST_DONE  = 3'd6
  } dma_state_e;

endpackage

// File: rtl/paula_floppy_dma_ctrl.sv
// -----------------------------------------------------------------------------
// paula_floppy_dma_ctrl
// Paula floppy disk DMA sequencer. DSKLEN must be written twice with DMAEN=1
// to start a transfer; the block then requests chip-bus DMA slots and strobes
// the external FIFO until the word count runs out, raising a one-enable-cycle
// block-done interrupt at the end. A DSKLEN write with DMAEN=0 aborts at any
// time without an interrupt.
//
// Ports
//   clk_i, clk7_en_i      bus clock and the enable that advances all state
//   reset_i               synchronous active-high reset (qualified by enable)
//   dsklen_i, dsklen_wr_i DSKLEN value and write strobe
//   wordsync_en_i         read transfers wait for the sync word first
//   sync_match_i          sync word detected
//   fifo_cnt_i/empty_i    FIFO fill level / empty flag
//   dma_ack_i             DMA slot granted this cycle
//   dma_req_o             DMA slot request (combinational)
//   dma_dir_o             1 = memory-to-disk, 0 = disk-to-memory
//   fifo_rd_o/fifo_wr_o   FIFO pop / push strobes
//   fifo_reset_o          FIFO pointer clear pulse
//   int_dskblk_o          block-done interrupt
//   busy_o                controller not idle
//   len_rem_o             words remaining
// -----------------------------------------------------------------------------
module paula_floppy_dma_ctrl
  import paula_floppy_dma_ctrl_pkg::*;
#(
  parameter logic [11:0] HIWATER = 12'd1536,
  parameter logic [11:0] LOWATER = 12'd1
) (
  input  logic        clk_i,
  input  logic        clk7_en_i,
  input  logic        reset_i,
  input  logic [15:0] dsklen_i,
  input  logic        dsklen_wr_i,
  input  logic        wordsync_en_i,
  input  logic        sync_match_i,
  input  logic [11:0] fifo_cnt_i,
  input  logic        fifo_empty_i,
  input  logic        dma_ack_i,
  output logic        dma_req_o,
  output logic        dma_dir_o,
  output logic        fifo_rd_o,
  output logic        fifo_wr_o,
  output logic        fifo_reset_o,
  output logic        int_dskblk_o,
  output logic        busy_o,
  output logic [13:0] len_rem_o
);

  dma_state_e  state_q, state_d;
  logic [13:0] len_q, len_d;
  logic        dir_q, dir_d;
  logic        wr_en_s;
  logic        wr_dis_s;
  logic        xfer_s;

  // Register writes only count on enable cycles
  assign wr_en_s  = clk7_en_i & dsklen_wr_i &  dsklen_i[DSKLEN_DMAEN];
  assign wr_dis_s = clk7_en_i & dsklen_wr_i & ~dsklen_i[DSKLEN_DMAEN];

  // DMA request, FIFO strobes and interrupt for the current state
  always_comb begin
    dma_req_o    = 1'b0;
    case (state_q)
      ST_READ:  dma_req_o = (fifo_cnt_i >= LOWATER) && !fifo_empty_i;
      ST_WRITE: dma_req_o = (fifo_cnt_i < HIWATER);
      default:  dma_req_o = 1'b0;
    endcase
    if (reset_i) begin
      dma_req_o = 1'b0;
    end else begin
      dma_req_o = dma_req_o;
    end
    // An abort in the same cycle wins over a granted slot
    xfer_s       = clk7_en_i & dma_req_o & dma_ack_i & ~wr_dis_s & ~reset_i;
    fifo_rd_o    = xfer_s & (state_q == ST_READ);
    fifo_wr_o    = xfer_s & (state_q == ST_WRITE);
    int_dskblk_o = (state_q == ST_DONE) & ~reset_i & ~wr_dis_s;
  end

  // Next-state logic and FIFO clear pulse
  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    dir_d        = dir_q;
    fifo_reset_o = 1'b0;
    if (wr_dis_s) begin
      state_d      = ST_IDLE;
      fifo_reset_o = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (wr_en_s) begin
            state_d = ST_ARMED;
            len_d   = dsklen_i[DSKLEN_LEN_MSB:0];
            dir_d   = dsklen_i[DSKLEN_WRITE];
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (wr_en_s) begin
            // A zero-length block completes without touching the FIFO
            if (len_q == 14'd0) begin
              state_d = ST_DONE;
            end else if (dir_q) begin
              state_d      = ST_WRITE;
              fifo_reset_o = 1'b1;
            end else if (wordsync_en_i) begin
              state_d      = ST_SYNC;
              fifo_reset_o = 1'b1;
            end else begin
              state_d      = ST_READ;
              fifo_reset_o = 1'b1;
            end
          end else begin
            state_d = ST_ARMED;
          end
        end
        ST_SYNC: begin
          if (clk7_en_i && sync_match_i) state_d = ST_READ;
          else                           state_d = ST_SYNC;
        end
        ST_READ, ST_WRITE: begin
          if (xfer_s && (len_q != 14'd0)) begin
            len_d = len_q - 14'd1;
            if (len_q == 14'd1) begin
              state_d = (state_q == ST_READ) ? ST_DONE : ST_DRAIN;
            end else begin
              state_d = state_q;
            end
          end else begin
            state_d = state_q;
          end
        end
        ST_DRAIN: begin
          if (clk7_en_i && fifo_empty_i) state_d = ST_DONE;
          else                           state_d = ST_DRAIN;
        end
        ST_DONE: begin
          if (clk7_en_i) state_d = ST_IDLE;
          else           state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (reset_i) begin
      fifo_reset_o = clk7_en_i;
    end else begin
      fifo_reset_o = fifo_reset_o;
    end
  end

  // State, word count and direction registers, advanced on enable cycles
  always_ff @(posedge clk_i) begin
    if (clk7_en_i) begin
      if (reset_i) begin
        state_q <= ST_IDLE;
        len_q   <= 14'd0;
        dir_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        len_q   <= len_d;
        dir_q   <= dir_d;
      end
    end
  end

  assign busy_o    = (state_q != ST_IDLE);
  assign dma_dir_o = dir_q;
  assign len_rem_o = len_q;

endmodule

// File: tb/tb_paula_floppy_dma_ctrl.sv
module tb_paula_floppy_dma_ctrl;

  localparam logic [11:0] HI  = 12'd1536;
  localparam logic [11:0] LOW = 12'd1;

  // Model phases (bench-local, independent of the RTL encoding)
  localparam int P_IDLE = 0, P_ARM = 1, P_SY = 2, P_RD = 3, P_WR = 4, P_DR = 5, P_DN = 6;

  logic        clk = 1'b0;
  logic        clk7_en = 1'b1;
  logic        reset = 1'b1;
  logic [15:0] dsklen = 16'h0000;
  logic        dsklen_wr = 1'b0;
  logic        wordsync_en = 1'b0;
  logic        sync_match = 1'b0;
  logic [11:0] fifo_cnt = 12'd0;
  logic        fifo_empty = 1'b1;
  logic        dma_ack = 1'b0;
  logic        dma_req_o, dma_dir_o, fifo_rd_o, fifo_wr_o, fifo_reset_o, int_dskblk_o, busy_o;
  logic [13:0] len_rem_o;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // model state
  int          m_ph  = P_IDLE;
  logic [13:0] m_rem = 14'd0;
  logic        m_dir = 1'b0;

  // observed DUT event counters (enable cycles)
  int d_rd = 0, d_wr = 0, d_irq = 0, d_req = 0;

  paula_floppy_dma_ctrl #(.HIWATER(HI), .LOWATER(LOW)) dut (
    .clk_i(clk), .clk7_en_i(clk7_en), .reset_i(reset),
    .dsklen_i(dsklen), .dsklen_wr_i(dsklen_wr),
    .wordsync_en_i(wordsync_en), .sync_match_i(sync_match),
    .fifo_cnt_i(fifo_cnt), .fifo_empty_i(fifo_empty), .dma_ack_i(dma_ack),
    .dma_req_o(dma_req_o), .dma_dir_o(dma_dir_o),
    .fifo_rd_o(fifo_rd_o), .fifo_wr_o(fifo_wr_o), .fifo_reset_o(fifo_reset_o),
    .int_dskblk_o(int_dskblk_o), .busy_o(busy_o), .len_rem_o(len_rem_o)
  );

  always #5 clk = ~clk;

  // Compare against the model every cycle, then advance the model
  always @(negedge clk) begin : cmp_proc
    logic abort, start, req, xfer, irq, frst;
    logic [20:0] exp_v, act_v;
    abort = clk7_en && dsklen_wr && !dsklen[15];
    start = clk7_en && dsklen_wr &&  dsklen[15];
    req = 1'b0;
    if (!reset && m_ph == P_RD) req = (fifo_cnt >= LOW) && !fifo_empty;
    if (!reset && m_ph == P_WR) req = (fifo_cnt < HI);
    xfer = clk7_en && req && dma_ack && !abort && !reset;
    irq  = (m_ph == P_DN) && !reset && !abort;
    frst = clk7_en && (reset || abort || (m_ph == P_ARM && start && m_rem != 14'd0));
    exp_v = {req, m_dir, xfer && (m_ph == P_RD), xfer && (m_ph == P_WR), frst, irq,
             (m_ph != P_IDLE), m_rem};
    act_v = {dma_req_o, dma_dir_o, fifo_rd_o, fifo_wr_o, fifo_reset_o, int_dskblk_o,
             busy_o, len_rem_o};
    if (chk_en) begin
      tests++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_cmp t=%0t act=%06h exp=%06h (req,dir,rd,wr,frst,irq,busy,len)",
                 $time, act_v, exp_v);
      end
    end
    if (clk7_en && fifo_rd_o === 1'b1) d_rd++;
    if (clk7_en && fifo_wr_o === 1'b1) d_wr++;
    if (clk7_en && int_dskblk_o === 1'b1) d_irq++;
    if (dma_req_o === 1'b1) d_req++;
    if (clk7_en) begin
      if (reset) begin
        m_ph = P_IDLE; m_rem = 14'd0; m_dir = 1'b0;
      end else if (abort) begin
        m_ph = P_IDLE;
      end else begin
        case (m_ph)
          P_IDLE: if (start) begin m_ph = P_ARM; m_rem = dsklen[13:0]; m_dir = dsklen[14]; end
          P_ARM:  if (start) m_ph = (m_rem == 14'd0) ? P_DN : m_dir ? P_WR : wordsync_en ? P_SY : P_RD;
          P_SY:   if (sync_match) m_ph = P_RD;
          P_RD, P_WR: if (xfer) begin
            m_rem = m_rem - 14'd1;
            if (m_rem == 14'd0) m_ph = (m_ph == P_RD) ? P_DN : P_DR;
          end
          P_DR:   if (fifo_empty) m_ph = P_DN;
          default: m_ph = P_IDLE;
        endcase
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic dwrite(input logic [15:0] v);
    dsklen = v; dsklen_wr = 1'b1;
    cyc();
    dsklen_wr = 1'b0;
  endtask

  task automatic wait_idle(input string nm, input int maxc, input bit alt_ack);
    bit ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      dma_ack = alt_ack ? (i % 2 == 1) : 1'b1;
      cyc();
      if (busy_o === 1'b0) begin ok = 1'b1; break; end
    end
    dma_ack = 1'b0;
    chk(nm, {31'd0, ok}, 32'd1);
  endtask

  initial begin : stim
    int r0, w0, i0, q0;
    bit hit;
    // reset
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    chk("rst_len", {18'd0, len_rem_o}, 32'd0);
    chk("rst_frst", {31'd0, fifo_reset_o}, 32'd1);
    reset = 1'b0;
    cyc();

    // read 4 words, ack every second cycle
    r0 = d_rd; i0 = d_irq;
    fifo_cnt = 12'd10; fifo_empty = 1'b0;
    dwrite(16'h8004); dwrite(16'h8004);
    wait_idle("t1_idle", 40, 1'b1);
    chk("t1_rd", d_rd - r0, 32'd4);
    chk("t1_len", {18'd0, len_rem_o}, 32'd0);
    chk("t1_irq", d_irq - i0, 32'd1);

    // write 3 words, then drain
    w0 = d_wr; i0 = d_irq;
    fifo_cnt = 12'd0; fifo_empty = 1'b1;
    dwrite(16'hC003); dwrite(16'hC003);
    dma_ack = 1'b1;
    repeat (3) cyc();
    dma_ack = 1'b0; fifo_empty = 1'b0; fifo_cnt = 12'd3;
    chk("t2_wr", d_wr - w0, 32'd3);
    chk("t2_len", {18'd0, len_rem_o}, 32'd0);
    repeat (5) cyc();
    chk("t2_drain_busy", {31'd0, busy_o}, 32'd1);
    chk("t2_drain_req", {31'd0, dma_req_o}, 32'd0);
    chk("t2_no_irq_yet", d_irq - i0, 32'd0);
    fifo_empty = 1'b1; fifo_cnt = 12'd0;
    wait_idle("t2_idle", 10, 1'b0);
    chk("t2_irq", d_irq - i0, 32'd1);

    // read with word sync
    r0 = d_rd; i0 = d_irq;
    wordsync_en = 1'b1; fifo_cnt = 12'd10; fifo_empty = 1'b0;
    dwrite(16'h8002); dwrite(16'h8002);
    q0 = d_req;
    dma_ack = 1'b1;
    repeat (6) cyc();
    chk("t3_no_req", d_req - q0, 32'd0);
    chk("t3_no_rd", d_rd - r0, 32'd0);
    sync_match = 1'b1; cyc(); sync_match = 1'b0;
    wordsync_en = 1'b0;
    wait_idle("t3_idle", 20, 1'b0);
    chk("t3_rd", d_rd - r0, 32'd2);
    chk("t3_irq", d_irq - i0, 32'd1);

    // abort mid-read at len_rem=5
    i0 = d_irq;
    dwrite(16'h8009); dwrite(16'h8009);
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      dma_ack = 1'b1; cyc();
      if (len_rem_o == 14'd5) begin hit = 1'b1; break; end
    end
    dma_ack = 1'b0;
    chk("t4_reach5", {31'd0, hit}, 32'd1);
    dsklen = 16'h0000; dsklen_wr = 1'b1;
    #2;
    chk("t4_frst", {31'd0, fifo_reset_o}, 32'd1);
    cyc(); dsklen_wr = 1'b0;
    chk("t4_idle", {31'd0, busy_o}, 32'd0);
    repeat (3) cyc();
    chk("t4_no_irq", d_irq - i0, 32'd0);

    // zero-length block
    r0 = d_rd; w0 = d_wr; i0 = d_irq;
    dwrite(16'h8000); dwrite(16'h8000);
    chk("t5_irq_now", {31'd0, int_dskblk_o}, 32'd1);
    cyc();
    chk("t5_idle", {31'd0, busy_o}, 32'd0);
    chk("t5_irq", d_irq - i0, 32'd1);
    chk("t5_strobes", (d_rd - r0) + (d_wr - w0), 32'd0);

    // write watermark and reset mid-transfer
    i0 = d_irq;
    fifo_cnt = 12'd1536; fifo_empty = 1'b0;
    dwrite(16'hC005); dwrite(16'hC005);
    chk("t6_req_hi", {31'd0, dma_req_o}, 32'd0);
    fifo_cnt = 12'd1535; #1;
    chk("t6_req_lo", {31'd0, dma_req_o}, 32'd1);
    reset = 1'b1; #1;
    chk("t6_rst_frst", {31'd0, fifo_reset_o}, 32'd1);
    cyc(); reset = 1'b0; #1;
    chk("t6_busy", {31'd0, busy_o}, 32'd0);
    chk("t6_len", {18'd0, len_rem_o}, 32'd0);
    chk("t6_dir", {31'd0, dma_dir_o}, 32'd0);
    chk("t6_req", {31'd0, dma_req_o}, 32'd0);
    cyc();
    chk("t6_no_irq", d_irq - i0, 32'd0);

    // randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 4000; n++) begin
      clk7_en     = ($urandom_range(0, 3) != 0);
      reset       = ($urandom_range(0, 299) == 0);
      dma_ack     = $urandom_range(0, 1);
      sync_match  = ($urandom_range(0, 7) == 0);
      wordsync_en = $urandom_range(0, 1);
      case ($urandom_range(0, 3))
        0:       fifo_cnt = 12'd0;
        1:       fifo_cnt = 12'($urandom_range(1534, 1538));
        default: fifo_cnt = 12'($urandom_range(0, 2000));
      endcase
      fifo_empty = (fifo_cnt == 12'd0) || ($urandom_range(0, 9) == 0);
      dsklen_wr  = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 9) == 0) dsklen = {2'b00, 14'($urandom_range(0, 6))};
      else dsklen = {1'b1, 1'($urandom_range(0, 1)), 14'($urandom_range(0, 6))};
      cyc();
    end
    clk7_en = 1'b1; reset = 1'b0; dsklen_wr = 1'b0; dma_ack = 1'b0;
    cyc();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
